repetition_monitor: RTL and testbench



---
 rtl/repetition_monitor.sv | 150 +++++++++++++++
 tb/tb_repetition_monitor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/repetition_monitor.sv
// Multi-slot repetition monitor: consecutive, goto and bounded non-consecutive.
// Each attempt yields one registered pass or fail pulse; failures saturate a counter.
package repetition_monitor_pkg;
    typedef enum logic [1:0] {CONSECUTIVE, GOTO, NONCONSECUTIVE} rep_kind_e;
endpackage

module repetition_monitor
    import repetition_monitor_pkg::*;
#(
    parameter rep_kind_e REPETITION_KIND = CONSECUTIVE,
    parameter int REP_COUNT  = 5,
    parameter int MAX_WINDOW = 16,
    parameter int NUM_SLOTS  = 4,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 busy,
    output logic [NUM_SLOTS-1:0] pass_vec,
    output logic [NUM_SLOTS-1:0] fail_vec,
    output logic [CNT_W-1:0]     err_count,
    output logic [NUM_SLOTS-1:0] active,
    output logic                 ovf
);
    typedef enum logic {IDLE, RUN} slot_state_e;

    localparam logic [4:0]     N5      = 5'(REP_COUNT);
    localparam logic [4:0]     N5P1    = 5'(REP_COUNT + 1);
    localparam logic [8:0]     W9      = 9'(MAX_WINDOW);
    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    slot_state_e state [NUM_SLOTS];
    logic [3:0]  hits  [NUM_SLOTS];
    logic [7:0]  win   [NUM_SLOTS];
    logic [4:0]  hit_n [NUM_SLOTS];
    logic [8:0]  win_n [NUM_SLOTS];

    logic [NUM_SLOTS-1:0] run;
    logic [NUM_SLOTS-1:0] grant;
    logic [NUM_SLOTS-1:0] dec_pass;
    logic [NUM_SLOTS-1:0] dec_fail;
    logic [CNT_W:0]       err_sum;
    logic [CNT_W-1:0]     err_next;

    always_comb begin
        run      = '0;
        grant    = '0;
        dec_pass = '0;
        dec_fail = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            run[i]   = (state[i] == RUN);
            hit_n[i] = {1'b0, hits[i]} + 5'(busy);
            win_n[i] = {1'b0, win[i]} + 9'd1;
        end
        // Walk downwards so the lowest idle slot wins.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!run[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (run[i]) begin
                unique case (REPETITION_KIND)
                    CONSECUTIVE: begin
                        if (!busy)
                            dec_fail[i] = 1'b1;
                        else if (hit_n[i] == N5)
                            dec_pass[i] = 1'b1;
                    end
                    GOTO: begin
                        if (hit_n[i] == N5)
                            dec_pass[i] = 1'b1;
                        else if (win_n[i] == W9)
                            dec_fail[i] = 1'b1;
                    end
                    default: begin
                        if (hit_n[i] == N5P1)
                            dec_fail[i] = 1'b1;
                        else if (win_n[i] == W9) begin
                            dec_pass[i] = (hit_n[i] == N5);
                            dec_fail[i] = (hit_n[i] != N5);
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        err_sum = {1'b0, err_count};
        for (int i = 0; i < NUM_SLOTS; i++)
            err_sum = err_sum + (CNT_W+1)'(dec_fail[i]);
        err_next = (err_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0]
                                       : err_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state[i] <= IDLE;
                hits[i]  <= '0;
                win[i]   <= '0;
            end
            pass_vec  <= '0;
            fail_vec  <= '0;
            err_count <= '0;
            ovf       <= 1'b0;
        end else begin
            pass_vec  <= dec_pass;
            fail_vec  <= dec_fail;
            err_count <= err_next;
            if (start && grant == '0)
                ovf <= 1'b1;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (start && grant[i]) begin
                    state[i] <= RUN;
                    hits[i]  <= '0;
                    win[i]   <= '0;
                end else if (run[i]) begin
                    if (dec_pass[i] || dec_fail[i])
                        state[i] <= IDLE;
                    hits[i] <= hit_n[i][3:0];
                    win[i]  <= win_n[i][7:0];
                end
            end
        end
    end

    assign active = run;

`ifndef SYNTHESIS
    cov_pass: cover property (@(posedge clk) disable iff (!rst_n) |pass_vec);
`ifdef REPETITION_MONITOR_SVA
    generate
        if (REPETITION_KIND == CONSECUTIVE) begin : g_sva_c
            a_rep: assert property (@(posedge clk) disable iff (!rst_n)
                start |=> busy[*REP_COUNT]);
        end else if (REPETITION_KIND == GOTO) begin : g_sva_g
            a_rep: assert property (@(posedge clk) disable iff (!rst_n)
                start |=> (busy[->REP_COUNT] intersect 1'b1[*1:MAX_WINDOW]));
        end else begin : g_sva_n
            a_rep: assert property (@(posedge clk) disable iff (!rst_n)
                start |=> (busy[=REP_COUNT] intersect 1'b1[*MAX_WINDOW]));
        end
    endgenerate
`endif
`endif
endmodule

// File: tb/tb_repetition_monitor.sv
// Directed bench for repetition_monitor across all three kinds,
// slot overflow and mid-attempt reset.
module tb_repetition_monitor;
    import repetition_monitor_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy  = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    logic [3:0] c_pass, c_fail, c_act;
    logic [7:0] c_err;
    logic       c_ovf;
    logic [3:0] g_pass, g_fail, g_act;
    logic [7:0] g_err;
    logic       g_ovf;
    logic [3:0] n_pass, n_fail_v, n_act;
    logic [7:0] n_err;
    logic       n_ovf;
    logic [1:0] o_pass, o_fail, o_act;
    logic [7:0] o_err;
    logic       o_ovf;

    repetition_monitor #(
        .REPETITION_KIND(CONSECUTIVE), .REP_COUNT(5), .MAX_WINDOW(16),
        .NUM_SLOTS(4), .CNT_W(8)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .pass_vec(c_pass), .fail_vec(c_fail), .err_count(c_err),
        .active(c_act), .ovf(c_ovf)
    );

    repetition_monitor #(
        .REPETITION_KIND(GOTO), .REP_COUNT(3), .MAX_WINDOW(8),
        .NUM_SLOTS(4), .CNT_W(8)
    ) dut_g (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .pass_vec(g_pass), .fail_vec(g_fail), .err_count(g_err),
        .active(g_act), .ovf(g_ovf)
    );

    repetition_monitor #(
        .REPETITION_KIND(NONCONSECUTIVE), .REP_COUNT(2), .MAX_WINDOW(6),
        .NUM_SLOTS(4), .CNT_W(8)
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .pass_vec(n_pass), .fail_vec(n_fail_v), .err_count(n_err),
        .active(n_act), .ovf(n_ovf)
    );

    repetition_monitor #(
        .REPETITION_KIND(CONSECUTIVE), .REP_COUNT(5), .MAX_WINDOW(16),
        .NUM_SLOTS(2), .CNT_W(8)
    ) dut_o (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .pass_vec(o_pass), .fail_vec(o_fail), .err_count(o_err),
        .active(o_act), .ovf(o_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one edge's inputs; returns in the cycle after that edge.
    task automatic step(input logic s, input logic b);
        start = s;
        busy  = b;
        @(negedge clk);
    endtask

    task automatic do_reset;
        start = 1'b0;
        busy  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Start at edge 0, busy = pat[e] at edges 0..last.
    task automatic run_pat(input logic [15:0] pat, input int last);
        for (int e = 0; e <= last; e++)
            step(e == 0, pat[e]);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_pass", 32'(c_pass), 0);
        chk("rst_fail", 32'(c_fail), 0);
        chk("rst_act", 32'(c_act), 0);
        chk("rst_err", 32'(c_err), 0);
        chk("rst_ovf", 32'(c_ovf), 0);
        rst_n = 1'b1;

        // Consecutive pass; busy at the start edge is deliberately low.
        run_pat(16'h003E, 4);
        chk("c_pass_c5", 32'(c_pass), 0);
        chk("c_act_c5", 32'(c_act), 4'b0001);
        step(1'b0, 1'b1);
        chk("c_pass_c6", 32'(c_pass), 4'b0001);
        chk("c_fail_c6", 32'(c_fail), 0);
        chk("c_err_c6", 32'(c_err), 0);
        chk("c_act_c6", 32'(c_act), 0);
        step(1'b0, 1'b0);
        chk("c_pass_c7", 32'(c_pass), 0);

        // Consecutive fail at edge 3.
        do_reset();
        run_pat(16'h0007, 2);
        chk("c2_act_c3", 32'(c_act), 4'b0001);
        step(1'b0, 1'b0);
        chk("c2_fail_c4", 32'(c_fail), 4'b0001);
        chk("c2_err_c4", 32'(c_err), 1);
        chk("c2_act_c4", 32'(c_act), 0);
        step(1'b0, 1'b0);
        chk("c2_fail_c5", 32'(c_fail), 0);
        chk("c2_err_c5", 32'(c_err), 1);

        // Goto pass: hits at 2,5,7; start-edge busy must not count.
        do_reset();
        run_pat(16'h00A5, 6);
        chk("g_pass_c7", 32'(g_pass), 0);
        step(1'b0, 1'b1);
        chk("g_pass_c8", 32'(g_pass), 4'b0001);
        chk("g_err_c8", 32'(g_err), 0);

        // Goto fail: only two hits by the window end.
        do_reset();
        run_pat(16'h0024, 7);
        chk("g2_fail_c8", 32'(g_fail), 0);
        chk("g2_act_c8", 32'(g_act), 4'b0001);
        step(1'b0, 1'b0);
        chk("g2_fail_c9", 32'(g_fail), 4'b0001);
        chk("g2_err_c9", 32'(g_err), 1);

        // Non-consecutive pass: exactly two hits in the window.
        do_reset();
        run_pat(16'h0012, 5);
        chk("n_pass_c6", 32'(n_pass), 0);
        chk("n_act_c6", 32'(n_act), 4'b0001);
        step(1'b0, 1'b0);
        chk("n_pass_c7", 32'(n_pass), 4'b0001);
        chk("n_err_c7", 32'(n_err), 0);

        // Non-consecutive early fail on the third hit.
        do_reset();
        run_pat(16'h000A, 4);
        chk("n2_fail_c5", 32'(n_fail_v), 0);
        step(1'b0, 1'b1);
        chk("n2_fail_c6", 32'(n_fail_v), 4'b0001);
        chk("n2_err_c6", 32'(n_err), 1);
        chk("n2_act_c6", 32'(n_act), 0);

        // Two slots, three starts: the third is dropped.
        do_reset();
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("o_ovf_c2", 32'(o_ovf), 0);
        step(1'b1, 1'b1);
        chk("o_ovf_c3", 32'(o_ovf), 1);
        chk("o_act_c3", 32'(o_act), 2'b11);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("o_pass_c5", 32'(o_pass), 0);
        step(1'b0, 1'b1);
        chk("o_pass_c6", 32'(o_pass), 2'b01);
        step(1'b0, 1'b1);
        chk("o_pass_c7", 32'(o_pass), 2'b10);
        chk("o_err_c7", 32'(o_err), 0);
        chk("o_ovf_c7", 32'(o_ovf), 1);

        // Reset at edge 3 of a running attempt.
        do_reset();
        run_pat(16'h0006, 2);
        busy = 1'b1;
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        chk("r_act", 32'(c_act), 0);
        chk("r_pass", 32'(c_pass), 0);
        chk("r_fail", 32'(c_fail), 0);
        chk("r_err", 32'(c_err), 0);
        chk("r_ovf", 32'(o_ovf), 0);
        @(negedge clk);
        @(negedge clk);
        chk("r_pass_hold", 32'(c_pass | c_fail), 0);
        rst_n = 1'b1;
        run_pat(16'h003E, 4);
        chk("r2_pass_c5", 32'(c_pass), 0);
        step(1'b0, 1'b1);
        chk("r2_pass_c6", 32'(c_pass), 4'b0001);
        chk("r2_err_c6", 32'(c_err), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
